// File: rtl/fifo_read_arbiter.sv
// Round-robin read arbiter sharing one registered output port among NUM_FIFOS FWFT FIFOs.
// Define FIFO_ARB_FIXED_PRIORITY_EN to pick the lowest-index non-empty FIFO instead of round-robin.
//
// state | meaning
// IDLE  | no owner; waiting for any FIFO to go non-empty
// GRANT | grant holds the owner; pops it whenever the output stage can accept
module fifo_read_arbiter #(
    parameter int NUM_FIFOS = 2,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4,
    parameter int BCW       = $clog2(MAX_BURST + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_FIFOS-1:0]       empty,
    input  logic [NUM_FIFOS*WIDTH-1:0] fifo_data,
    output logic [NUM_FIFOS-1:0]       pop,
    output logic [NUM_FIFOS-1:0]       grant,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       busy
);
    localparam int IW = $clog2(NUM_FIFOS);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_FIFOS-1:0] grant_q, grant_d;
    logic [IW-1:0]        last_q, last_d;
    logic [BCW-1:0]       burst_cnt_q, burst_cnt_d;
    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     out_data_q, out_data_d;

    logic                 accept;
    logic                 any_pop;
    logic                 owner_empty;
    logic                 release_own;
    logic                 pick_found;
    logic [IW-1:0]        pick_idx;
    logic [NUM_FIFOS-1:0] pick_onehot;
    logic [WIDTH-1:0]     owner_data;

    // Pick uses this cycle's empty vector; in round-robin the search starts
    // just above last and ends on last itself.
    always_comb begin
        int idx;
        idx        = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
`ifdef FIFO_ARB_FIXED_PRIORITY_EN
        for (int i = NUM_FIFOS - 1; i >= 0; i--) begin
            if (!empty[i]) begin
                pick_found = 1'b1;
                pick_idx   = IW'(i);
            end
        end
`else
        for (int k = 1; k <= NUM_FIFOS; k++) begin
            idx = (int'(last_q) + k) % NUM_FIFOS;
            for (int i = 0; i < NUM_FIFOS; i++) begin
                if (!pick_found && (i == idx) && !empty[i]) begin
                    pick_found = 1'b1;
                    pick_idx   = IW'(i);
                end
            end
        end
`endif
        for (int i = 0; i < NUM_FIFOS; i++) begin
            pick_onehot[i] = pick_found && (pick_idx == IW'(i));
        end
    end

    always_comb begin
        owner_data  = '0;
        owner_empty = 1'b0;
        for (int i = 0; i < NUM_FIFOS; i++) begin
            if (grant_q[i]) begin
                owner_data  = fifo_data[i*WIDTH +: WIDTH];
                owner_empty = empty[i];
            end
        end
    end

    always_comb begin
        accept = !out_valid_q || out_ready;
        for (int i = 0; i < NUM_FIFOS; i++) begin
            pop[i] = rst && (state_q == GRANT) && grant_q[i] && !empty[i] && accept;
        end
        any_pop = |pop;
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        burst_cnt_d = burst_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        release_own = 1'b0;

        if (any_pop) begin
            out_data_d  = owner_data;
            out_valid_d = 1'b1;
            burst_cnt_d = burst_cnt_q + BCW'(1);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d     = GRANT;
                    grant_d     = pick_onehot;
                    last_d      = pick_idx;
                    burst_cnt_d = '0;
                end
            end
            GRANT: begin
                // Stalled cycles never pop, so only real transfers reach the limit.
                release_own = owner_empty ||
                              (any_pop && (burst_cnt_q == BCW'(MAX_BURST - 1)));
                if (release_own) begin
                    burst_cnt_d = '0;
                    if (pick_found) begin
                        grant_d = pick_onehot;
                        last_d  = pick_idx;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            last_q      <= IW'(NUM_FIFOS - 1);
            burst_cnt_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign grant     = grant_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q == GRANT);

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Directed bench for fifo_read_arbiter: queue-modelled FWFT FIFOs feed the DUT and
// a scoreboard of expected output words is checked as downstream consumes them.
module tb_fifo_read_arbiter;
    localparam int N  = 2;
    localparam int W  = 8;
    localparam int MB = 4;

    logic           clk       = 1'b0;
    logic           rst       = 1'b0;
    logic [N-1:0]   empty     = '1;
    logic [N*W-1:0] fifo_data = '0;
    logic           out_ready = 1'b1;
    logic [N-1:0]   pop;
    logic [N-1:0]   grant;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           busy;

    logic [W-1:0] fq0[$];
    logic [W-1:0] fq1[$];
    logic [W-1:0] exp_q[$];

    int           n_asserts = 0;
    int           n_fail    = 0;
    logic [N-1:0] last_pop  = '0;

    always #5 clk = ~clk;

    fifo_read_arbiter #(
        .NUM_FIFOS(N),
        .WIDTH    (W),
        .MAX_BURST(MB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .empty    (empty),
        .fifo_data(fifo_data),
        .pop      (pop),
        .grant    (grant),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_asserts++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, req);
        end
    endtask

    task automatic drive_fifos();
        empty[0]           = (fq0.size() == 0);
        empty[1]           = (fq1.size() == 0);
        fifo_data[W-1:0]   = (fq0.size() != 0) ? fq0[0] : '0;
        fifo_data[2*W-1:W] = (fq1.size() != 0) ? fq1[0] : '0;
    endtask

    task automatic load(input int f, input logic [W-1:0] base, input int n);
        for (int j = 0; j < n; j++) begin
            if (f == 0) fq0.push_back(base + W'(j));
            else        fq1.push_back(base + W'(j));
        end
    endtask

    task automatic expect_seq(input logic [W-1:0] base, input int n);
        for (int j = 0; j < n; j++) exp_q.push_back(base + W'(j));
    endtask

    // One clock: sample pop and any consumed word before the edge, then
    // retire popped heads from the FIFO models after it.
    task automatic cycle();
        logic [W-1:0] want;
        #1;
        last_pop = pop;
        if (rst && out_valid && out_ready) begin
            n_asserts++;
            assert (exp_q.size() > 0) else begin
                n_fail++;
                $error("FAIL sb_extra: observed word 0x%0h, required no word", out_data);
            end
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                check("sb_data", 32'(out_data), 32'(want));
            end
        end
        @(posedge clk);
        #1;
        if (last_pop[0] && fq0.size() != 0) void'(fq0.pop_front());
        if (last_pop[1] && fq1.size() != 0) void'(fq1.pop_front());
        drive_fifos();
    endtask

    task automatic drain(input string tag, input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            cycle();
            k++;
        end
        check({tag, "_drained"}, 32'(exp_q.size()), 32'h0);
    endtask

    initial begin
        int bubbles;
        int k;
        int cnt;

        // Reset held with both FIFOs loaded
        rst       = 1'b0;
        out_ready = 1'b1;
        load(0, 8'hA0, 10);
        load(1, 8'hB0, 10);
        drive_fifos();
        repeat (3) begin
            cycle();
            check("rst_pop",       32'(last_pop),  32'h0);
            check("rst_grant",     32'(grant),     32'h0);
            check("rst_out_valid", 32'(out_valid), 32'h0);
            check("rst_out_data",  32'(out_data),  32'h0);
        end

        // Fairness / fixed priority with 10 words in each FIFO
`ifdef FIFO_ARB_FIXED_PRIORITY_EN
        expect_seq(8'hA0, 10);
        expect_seq(8'hB0, 10);
`else
        for (int r = 0; r < 3; r++) begin
            expect_seq(8'hA0 + W'(r * 4), (r < 2) ? 4 : 2);
            expect_seq(8'hB0 + W'(r * 4), (r < 2) ? 4 : 2);
        end
`endif
        rst = 1'b1;
        cycle();
        check("fair_first_grant", 32'(grant), 32'h1);
        bubbles = 0;
        k       = 0;
        while (exp_q.size() != 0 && k < 100) begin
            if (!out_valid && exp_q.size() != 20) bubbles++;
            cycle();
            k++;
        end
        check("fair_drained", 32'(exp_q.size()), 32'h0);
        check("fair_bubbles", 32'(bubbles),      32'h1);
        check("fair_idle",    32'(busy),         32'h0);
        check("fair_grant0",  32'(grant),        32'h0);

        // Single requester on FIFO1
        rst = 1'b0;
        load(1, 8'h11, 1);
        load(1, 8'h22, 1);
        load(1, 8'h33, 1);
        drive_fifos();
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        cycle();
        rst = 1'b1;
        cycle();
        check("single_grant", 32'(grant), 32'h2);
        repeat (3) begin
            cycle();
            check("single_pop", 32'(last_pop), 32'h2);
        end
        cycle();
        check("single_pop_end", 32'(last_pop),     32'h0);
        check("single_idle",    32'(busy),         32'h0);
        check("single_grant0",  32'(grant),        32'h0);
        check("single_words",   32'(exp_q.size()), 32'h0);

        // Backpressure after the second word of a burst
        load(0, 8'hD0, 6);
        load(1, 8'hE0, 2);
        drive_fifos();
`ifdef FIFO_ARB_FIXED_PRIORITY_EN
        expect_seq(8'hD0, 6);
        expect_seq(8'hE0, 2);
`else
        expect_seq(8'hD0, 4);
        expect_seq(8'hE0, 2);
        expect_seq(8'hD4, 2);
`endif
        cycle();
        check("bp_grant", 32'(grant), 32'h1);
        cycle();
        cycle();
        check("bp_word2_data",  32'(out_data),  32'hD1);
        check("bp_word2_valid", 32'(out_valid), 32'h1);
        out_ready = 1'b0;
        repeat (3) begin
            cycle();
            check("bp_stall_pop",   32'(last_pop),  32'h0);
            check("bp_stall_data",  32'(out_data),  32'hD1);
            check("bp_stall_valid", 32'(out_valid), 32'h1);
            check("bp_stall_grant", 32'(grant),     32'h1);
        end
        out_ready = 1'b1;
        cnt = 0;
        k   = 0;
        while (grant == 2'b01 && k < 20) begin
            cycle();
            cnt += int'(last_pop[0]);
            k++;
        end
`ifdef FIFO_ARB_FIXED_PRIORITY_EN
        check("bp_resume_pops", 32'(cnt), 32'h4);
`else
        check("bp_resume_pops", 32'(cnt), 32'h2);
`endif
        drain("bp", 50);
        check("bp_idle", 32'(busy), 32'h0);

        // Reset while the output register holds a word
        load(0, 8'h50, 4);
        drive_fifos();
        cycle();
        cycle();
        check("rstm_valid", 32'(out_valid), 32'h1);
        check("rstm_data",  32'(out_data),  32'h50);
        rst = 1'b0;
        cycle();
        check("rstm_pop",       32'(last_pop),  32'h0);
        check("rstm_out_valid", 32'(out_valid), 32'h0);
        check("rstm_grant",     32'(grant),     32'h0);
        check("rstm_busy",      32'(busy),      32'h0);
        expect_seq(8'h51, 3);
        rst = 1'b1;
        drain("rstm", 30);
        check("rstm_idle", 32'(busy), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
